// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: boundary PCs, exception codes,
// the slot record and the per-slot handshake operation.
package pipe_pkg;

    localparam int PAYLOAD_W_DEF = 128;
    localparam int PC_W_DEF      = 32;
    localparam int EXC_W_DEF     = 5;

    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef struct packed {
        logic                     valid;
        logic [PC_W_DEF-1:0]      pc;
        logic [PAYLOAD_W_DEF-1:0] payload;
        logic                     bd;
        logic [EXC_W_DEF-1:0]     exc;
    } slot_t;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_DROP = 2'd2
    } slot_op_e;

    function automatic logic [1:0] occ_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One registered pipeline entry. Clears beat the handshake op; DROP invalidates the
// entry but keeps its data so the PC stays observable during a bubble.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int               PAYLOAD_W = 128,
    parameter int               PC_W      = 32,
    parameter int               EXC_W     = 5,
    parameter logic [PC_W-1:0]  RESET_PC  = {PC_W{1'b0}},
    parameter logic [PC_W-1:0]  VEC_PC    = {PC_W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 clear_vec,
    input  slot_op_e             op,
    input  logic [PC_W-1:0]      d_pc,
    input  logic [PAYLOAD_W-1:0] d_payload,
    input  logic                 d_bd,
    input  logic [EXC_W-1:0]     d_exc,
    output logic                 q_valid,
    output logic [PC_W-1:0]      q_pc,
    output logic [PAYLOAD_W-1:0] q_payload,
    output logic                 q_bd,
    output logic [EXC_W-1:0]     q_exc
);

    logic                 valid_q,   valid_d;
    logic [PC_W-1:0]      pc_q,      pc_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 bd_q,      bd_d;
    logic [EXC_W-1:0]     exc_q,     exc_d;

    // Next entry: exception vector bubble, then plain bubble, then the handshake op
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        payload_d = payload_q;
        bd_d      = bd_q;
        exc_d     = exc_q;
        if (clear_vec) begin
            valid_d   = 1'b0;
            pc_d      = VEC_PC;
            payload_d = {PAYLOAD_W{1'b0}};
            bd_d      = 1'b0;
            exc_d     = {EXC_W{1'b0}};
        end else if (clear) begin
            valid_d   = 1'b0;
            pc_d      = RESET_PC;
            payload_d = {PAYLOAD_W{1'b0}};
            bd_d      = 1'b0;
            exc_d     = {EXC_W{1'b0}};
        end else begin
            case (op)
                OP_LOAD: begin
                    valid_d   = 1'b1;
                    pc_d      = d_pc;
                    payload_d = d_payload;
                    bd_d      = d_bd;
                    exc_d     = d_exc;
                end
                OP_DROP: valid_d = 1'b0;
                OP_HOLD: valid_d = valid_q;
                default: valid_d = valid_q;
            endcase
        end
    end

    // Entry registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= RESET_PC;
            payload_q <= {PAYLOAD_W{1'b0}};
            bd_q      <= 1'b0;
            exc_q     <= {EXC_W{1'b0}};
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            payload_q <= payload_d;
            bd_q      <= bd_d;
            exc_q     <= exc_d;
        end
    end

    assign q_valid   = valid_q;
    assign q_pc      = pc_q;
    assign q_payload = payload_q;
    assign q_bd      = bd_q;
    assign q_exc     = exc_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// in_ready and occupancy decode registered slot state only.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               PAYLOAD_W = 128,
    parameter int               PC_W      = 32,
    parameter int               EXC_W     = 5,
    parameter logic [PC_W-1:0]  EXC_VEC   = PC_W'(pipe_pkg::EXC_VEC),
    parameter logic [PC_W-1:0]  RESET_PC  = PC_W'(pipe_pkg::RESET_PC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 req,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_bd,
    input  logic [EXC_W-1:0]     in_exc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_bd,
    output logic [EXC_W-1:0]     out_exc,
    output logic [1:0]           occupancy
);

    logic                 main_valid_s, skid_valid_s;
    logic [PC_W-1:0]      skid_pc_s;
    logic [PAYLOAD_W-1:0] skid_payload_s;
    logic                 skid_bd_s;
    logic [EXC_W-1:0]     skid_exc_s;

    logic                 main_free_s, in_fire_s, main_from_skid_s;
    slot_op_e             main_op_s, skid_op_s;
    logic [PC_W-1:0]      main_d_pc_s;
    logic [PAYLOAD_W-1:0] main_d_payload_s;
    logic                 main_d_bd_s;
    logic [EXC_W-1:0]     main_d_exc_s;

    assign in_ready    = ~skid_valid_s;
    assign in_fire_s   = in_valid & in_ready;
    assign main_free_s = ~main_valid_s | out_ready;
    assign out_valid   = main_valid_s;
    assign occupancy   = occ_count(main_valid_s, skid_valid_s);

    // Slot operations; the skid always drains first so entries keep FIFO order
    always_comb begin
        main_op_s        = OP_HOLD;
        skid_op_s        = OP_HOLD;
        main_from_skid_s = 1'b0;
        if (main_free_s) begin
            if (skid_valid_s) begin
                main_op_s        = OP_LOAD;
                main_from_skid_s = 1'b1;
                if (in_fire_s) begin
                    skid_op_s = OP_LOAD;
                end else begin
                    skid_op_s = OP_DROP;
                end
            end else if (in_fire_s) begin
                main_op_s = OP_LOAD;
            end else begin
                main_op_s = OP_DROP;
            end
        end else begin
            if (in_fire_s) begin
                skid_op_s = OP_LOAD;
            end else begin
                skid_op_s = OP_HOLD;
            end
        end
    end

    // Main slot source select
    always_comb begin
        if (main_from_skid_s) begin
            main_d_pc_s      = skid_pc_s;
            main_d_payload_s = skid_payload_s;
            main_d_bd_s      = skid_bd_s;
            main_d_exc_s     = skid_exc_s;
        end else begin
            main_d_pc_s      = in_pc;
            main_d_payload_s = in_payload;
            main_d_bd_s      = in_bd;
            main_d_exc_s     = in_exc;
        end
    end

    // req wins over flush in the main slot; both empty the skid
    pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W),
        .PC_W      (PC_W),
        .EXC_W     (EXC_W),
        .RESET_PC  (RESET_PC),
        .VEC_PC    (EXC_VEC)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .clear_vec (req),
        .op        (main_op_s),
        .d_pc      (main_d_pc_s),
        .d_payload (main_d_payload_s),
        .d_bd      (main_d_bd_s),
        .d_exc     (main_d_exc_s),
        .q_valid   (main_valid_s),
        .q_pc      (out_pc),
        .q_payload (out_payload),
        .q_bd      (out_bd),
        .q_exc     (out_exc)
    );

    pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W),
        .PC_W      (PC_W),
        .EXC_W     (EXC_W),
        .RESET_PC  (RESET_PC),
        .VEC_PC    (RESET_PC)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush | req),
        .clear_vec (1'b0),
        .op        (skid_op_s),
        .d_pc      (in_pc),
        .d_payload (in_payload),
        .d_bd      (in_bd),
        .d_exc     (in_exc),
        .q_valid   (skid_valid_s),
        .q_pc      (skid_pc_s),
        .q_payload (skid_payload_s),
        .q_bd      (skid_bd_s),
        .q_exc     (skid_exc_s)
    );

endmodule
